operand_loader: RTL

//  Upstream entry stage for the LED calculator top level. Captures operand A, operand B
//  and the 3-bit operation select from one 3-bit switch bank, one debounced push-button

---
 rtl/calc_pkg.sv | 15 +
 rtl/btn_debounce.sv | 39 +++
 rtl/operand_loader.sv | 56 +++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared state encoding, opcode width and opcode constants for the LED calculator
package calc_pkg;
  localparam int OPW = 3;
  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;
  localparam logic [OPW-1:0] OP_ADD = 3'd0;
  localparam logic [OPW-1:0] OP_SUB = 3'd1;
  localparam logic [OPW-1:0] OP_MUL = 3'd2;
  localparam logic [OPW-1:0] OP_DIV = 3'd3;
  localparam logic [OPW-1:0] OP_MOD = 3'd4;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stability counter and rising-edge press pulse
// Ports: clk, rst_n (async, active-low), btn_raw (raw bouncing button), press (1-cycle pulse per debounced press)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q;
  logic btn_s, lvl_q, lvl_d, prev_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic done;
  assign btn_s = sync_q[1];
  assign done  = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  // The level only flips after btn_s has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    cnt_d = (btn_s == lvl_q || done) ? '0 : cnt_q + 1'b1;
    lvl_d = (btn_s != lvl_q && done) ? ~lvl_q : lvl_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      prev_q  <= lvl_q;
      press_q <= lvl_q & ~prev_q;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/operand_loader.sv
// operand_loader: captures A, B and ctrl from one switch bank, one debounced press per field
// Ports: clk, rst_n (async, active-low), sw (switch value), btn (raw button),
//        A/B/ctrl (captured fields), valid (set complete), phase (current state)
module operand_loader
  import calc_pkg::*;
#(
  parameter int W               = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   sw,
  input  logic           btn,
  output logic [W-1:0]   A,
  output logic [W-1:0]   B,
  output logic [OPW-1:0] ctrl,
  output logic           valid,
  output logic [1:0]     phase
);
  logic press;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0] ctrl_q, ctrl_d;
  logic valid_q, valid_d;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn), .press(press)
  );
  // Each press advances one state; SHOW wraps back to LOAD_A through the 2-bit increment.
  always_comb begin
    state_d = press ? state_t'(state_q + 2'd1) : state_q;
    a_d     = (press && state_q == LOAD_A)  ? sw : a_q;
    b_d     = (press && state_q == LOAD_B)  ? sw : b_q;
    ctrl_d  = (press && state_q == LOAD_OP) ? sw[OPW-1:0] : ctrl_q;
    valid_d = state_d == SHOW;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end
  assign A     = a_q;
  assign B     = b_q;
  assign ctrl  = ctrl_q;
  assign valid = valid_q;
  assign phase = state_q;
endmodule
